// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter onto a single-outstanding memory interface.
// Define MEM_ARB_RR_EN for round-robin contention; otherwise the data port always wins.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        memory_valid,
  output logic        memory_instr,
  output logic [31:0] memory_addr,
  output logic [31:0] memory_wdata,
  output logic [3:0]  memory_wstrb,
  input  logic [31:0] memory_rdata,
  input  logic        memory_ready
);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      state_r, state_s;
  logic        ipend_r, dpend_r;
  logic [31:0] iaddr_r, daddr_r, dwdata_r;
  logic [3:0]  dwstrb_r;
  logic        owner_instr_r;
`ifdef MEM_ARB_RR_EN
  logic        last_instr_r;
`endif

  logic        i_fly_s, d_fly_s, i_live_s, d_live_s, i_cand_s, d_cand_s;
  logic        done_s, can_issue_s, grant_i_s, grant_d_s, issue_s;
  logic [31:0] i_addr_sel_s, d_addr_sel_s, d_wdata_sel_s;
  logic [3:0]  d_wstrb_sel_s;

  // Candidate and grant selection; a live valid is ignored while its port is pending or in flight
  always_comb begin
    i_fly_s     = (state_r == WAIT) && owner_instr_r;
    d_fly_s     = (state_r == WAIT) && !owner_instr_r;
    i_live_s    = imem_valid && !ipend_r && !i_fly_s;
    d_live_s    = dmem_valid && !dpend_r && !d_fly_s;
    i_cand_s    = ipend_r || i_live_s;
    d_cand_s    = dpend_r || d_live_s;
    done_s      = (state_r == WAIT) && memory_ready;
    can_issue_s = (state_r == IDLE) || done_s;
    grant_i_s   = 1'b0;
    grant_d_s   = 1'b0;
    if (can_issue_s) begin
      if (i_cand_s && d_cand_s) begin
`ifdef MEM_ARB_RR_EN
        grant_i_s = !last_instr_r;
        grant_d_s = last_instr_r;
`else
        grant_d_s = 1'b1;
`endif
      end else if (d_cand_s) begin
        grant_d_s = 1'b1;
      end else if (i_cand_s) begin
        grant_i_s = 1'b1;
      end else begin
        grant_i_s = 1'b0;
      end
    end else begin
      grant_i_s = 1'b0;
    end
    issue_s       = grant_i_s || grant_d_s;
    i_addr_sel_s  = ipend_r ? iaddr_r  : imem_addr;
    d_addr_sel_s  = dpend_r ? daddr_r  : dmem_addr;
    d_wdata_sel_s = dpend_r ? dwdata_r : dmem_wdata;
    d_wstrb_sel_s = dpend_r ? dwstrb_r : dmem_wstrb;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = issue_s ? WAIT : IDLE;
      WAIT:    begin
        if (done_s) begin
          state_s = issue_s ? WAIT : IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Pending latches, ownership and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ipend_r       <= 1'b0;
      dpend_r       <= 1'b0;
      iaddr_r       <= 32'd0;
      daddr_r       <= 32'd0;
      dwdata_r      <= 32'd0;
      dwstrb_r      <= 4'd0;
      owner_instr_r <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_instr_r  <= 1'b1;
`endif
      memory_valid  <= 1'b0;
      memory_instr  <= 1'b0;
      memory_addr   <= 32'd0;
      memory_wdata  <= 32'd0;
      memory_wstrb  <= 4'd0;
      imem_ready    <= 1'b0;
      imem_rdata    <= 32'd0;
      dmem_ready    <= 1'b0;
      dmem_rdata    <= 32'd0;
    end else begin
      if (grant_i_s) begin
        ipend_r <= 1'b0;
      end else if (i_live_s) begin
        ipend_r <= 1'b1;
        iaddr_r <= imem_addr;
      end
      if (grant_d_s) begin
        dpend_r <= 1'b0;
      end else if (d_live_s) begin
        dpend_r  <= 1'b1;
        daddr_r  <= dmem_addr;
        dwdata_r <= dmem_wdata;
        dwstrb_r <= dmem_wstrb;
      end
      memory_valid <= issue_s;
      if (grant_i_s) begin
        memory_instr <= 1'b1;
        memory_addr  <= i_addr_sel_s;
        memory_wdata <= 32'd0;
        memory_wstrb <= 4'd0;
      end else if (grant_d_s) begin
        memory_instr <= 1'b0;
        memory_addr  <= d_addr_sel_s;
        memory_wdata <= d_wdata_sel_s;
        memory_wstrb <= d_wstrb_sel_s;
      end
      if (issue_s) begin
        owner_instr_r <= grant_i_s;
`ifdef MEM_ARB_RR_EN
        last_instr_r  <= grant_i_s;
`endif
      end
      imem_ready <= done_s && owner_instr_r;
      dmem_ready <= done_s && !owner_instr_r;
      if (done_s && owner_instr_r)  imem_rdata <= memory_rdata;
      if (done_s && !owner_instr_r) dmem_rdata <= memory_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level port/memory model.
// Honors MEM_ARB_RR_EN the same way the design does.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_valid = 1'b0, dmem_valid = 1'b0;
  logic [31:0] imem_addr = 32'd0, dmem_addr = 32'd0, dmem_wdata = 32'd0;
  logic [3:0]  dmem_wstrb = 4'd0;
  logic [31:0] imem_rdata, dmem_rdata, memory_addr, memory_wdata;
  logic        imem_ready, dmem_ready, memory_valid, memory_instr;
  logic [3:0]  memory_wstrb;
  logic [31:0] memory_rdata = 32'd0;
  logic        memory_ready = 1'b0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .memory_valid(memory_valid), .memory_instr(memory_instr), .memory_addr(memory_addr),
    .memory_wdata(memory_wdata), .memory_wstrb(memory_wstrb),
    .memory_rdata(memory_rdata), .memory_ready(memory_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Port 0 = instruction, port 1 = data
  logic        m_pend [2];
  logic        m_fly  [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wdata[2];
  logic [3:0]  m_wstrb[2];
  logic        m_busy;
  int          m_owner, m_last;
  logic        e_mvalid, e_minstr;
  logic [31:0] e_maddr, e_mwdata;
  logic [3:0]  e_mwstrb;
  logic        e_ready[2];
  logic [31:0] e_rdata[2];

  int          mem_cnt = 0, mem_lat = 0;
  logic        mem_fix = 1'b1, spur_en = 1'b0, spur_force = 1'b0;
  logic [31:0] mem_dat = 32'd0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_pend[p] = 1'b0; m_fly[p] = 1'b0; m_addr[p] = 32'd0; m_wdata[p] = 32'd0; m_wstrb[p] = 4'd0;
      e_ready[p] = 1'b0; e_rdata[p] = 32'd0;
    end
    m_busy = 1'b0; m_owner = 0; m_last = 0;
    e_mvalid = 1'b0; e_minstr = 1'b0; e_maddr = 32'd0; e_mwdata = 32'd0; e_mwstrb = 4'd0;
  endtask

  // What the arbiter must present after the coming rising edge
  task automatic model_step();
    logic acc[2];
    int   g;
    acc[0] = imem_valid && !m_pend[0] && !m_fly[0];
    acc[1] = dmem_valid && !m_pend[1] && !m_fly[1];
    e_mvalid = 1'b0; e_ready[0] = 1'b0; e_ready[1] = 1'b0;
    if (m_busy && memory_ready) begin
      e_ready[m_owner] = 1'b1;
      e_rdata[m_owner] = memory_rdata;
      m_fly[m_owner]   = 1'b0;
      m_busy           = 1'b0;
    end
    if (acc[0]) begin m_pend[0] = 1'b1; m_addr[0] = imem_addr; m_wdata[0] = 32'd0; m_wstrb[0] = 4'd0; end
    if (acc[1]) begin m_pend[1] = 1'b1; m_addr[1] = dmem_addr; m_wdata[1] = dmem_wdata; m_wstrb[1] = dmem_wstrb; end
    if (!m_busy && (m_pend[0] || m_pend[1])) begin
      if (m_pend[0] && m_pend[1]) begin
`ifdef MEM_ARB_RR_EN
        g = 1 - m_last;
`else
        g = 1;
`endif
      end else begin
        g = m_pend[1] ? 1 : 0;
      end
      e_mvalid = 1'b1; e_minstr = (g == 0);
      e_maddr = m_addr[g]; e_mwdata = m_wdata[g]; e_mwstrb = m_wstrb[g];
      m_pend[g] = 1'b0; m_fly[g] = 1'b1; m_busy = 1'b1; m_owner = g; m_last = g;
    end
  endtask

  task automatic cycle(input logic r, input logic iv, input logic [31:0] ia,
                       input logic dv, input logic [31:0] da, input logic [31:0] wd, input logic [3:0] ws);
    @(negedge clk);
    check_eq("memory_valid", memory_valid, e_mvalid);
    check_eq("memory_instr", memory_instr, e_minstr);
    check_eq("memory_addr",  memory_addr,  e_maddr);
    check_eq("memory_wdata", memory_wdata, e_mwdata);
    check_eq("memory_wstrb", memory_wstrb, e_mwstrb);
    check_eq("imem_ready",   imem_ready,   e_ready[0]);
    check_eq("imem_rdata",   imem_rdata,   e_rdata[0]);
    check_eq("dmem_ready",   dmem_ready,   e_ready[1]);
    check_eq("dmem_rdata",   dmem_rdata,   e_rdata[1]);
    memory_ready = 1'b0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        memory_ready = 1'b1;
        memory_rdata = mem_fix ? mem_dat : $urandom;
      end
    end else if (spur_force || (spur_en && !m_busy && !memory_valid && $urandom_range(0, 7) == 0)) begin
      memory_ready = 1'b1;
      memory_rdata = $urandom;
    end
    spur_force = 1'b0;
    if (memory_valid) mem_cnt = (mem_lat < 0) ? $urandom_range(1, 5) : mem_lat + 1;
    rst = r;
    imem_valid = iv; imem_addr = ia;
    dmem_valid = dv; dmem_addr = da; dmem_wdata = wd; dmem_wstrb = ws;
    if (r) model_reset();
    else   model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0);
    idle(1);
    check_eq("reset_memory_valid", memory_valid, 32'd0);
    check_eq("reset_imem_rdata", imem_rdata, 32'd0);
    spur_force = 1'b1;
    idle(3);

    // single fetch
    mem_fix = 1'b1; mem_lat = 0; mem_dat = 32'hDEADBEEF;
    cycle(1'b0, 1'b1, 32'h100, 1'b0, 32'd0, 32'd0, 4'd0);
    idle(1);
    check_eq("fetch_issue_instr", memory_instr, 32'd1);
    idle(2);
    check_eq("fetch_ready", imem_ready, 32'd1);
    check_eq("fetch_rdata", imem_rdata, 32'hDEADBEEF);
    idle(2);

    // store
    mem_dat = 32'h0000_55AA;
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'h1000, 32'h1, 4'hF);
    idle(1);
    check_eq("store_instr", memory_instr, 32'd0);
    check_eq("store_wstrb", memory_wstrb, 32'hF);
    idle(2);
    check_eq("store_dready", dmem_ready, 32'd1);
    check_eq("store_iready", imem_ready, 32'd0);
    idle(2);

    // fetch leaves last-grant on the instruction port before contention
    cycle(1'b0, 1'b1, 32'h104, 1'b0, 32'd0, 32'd0, 4'd0);
    idle(4);
    cycle(1'b0, 1'b1, 32'h200, 1'b1, 32'h2000, 32'hCAFE, 4'd0);
    idle(1);
    check_eq("contend1_first_data", memory_instr, 32'd0);
    idle(2);
    check_eq("contend1_dready", dmem_ready, 32'd1);
    check_eq("contend1_second_valid", memory_valid, 32'd1);
    check_eq("contend1_second_instr", memory_instr, 32'd1);
    idle(3);

    // store moves last-grant to data; second contended pair
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'h3000, 32'h7, 4'h3);
    idle(4);
    cycle(1'b0, 1'b1, 32'h300, 1'b1, 32'h4000, 32'hBEEF, 4'h1);
    idle(1);
`ifdef MEM_ARB_RR_EN
    check_eq("contend2_first", memory_instr, 32'd1);
`else
    check_eq("contend2_first", memory_instr, 32'd0);
`endif
    idle(5);

    // stalling memory with a fetch arriving mid-wait
    mem_lat = 5;
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'h5000, 32'h11, 4'h0);
    idle(2);
    cycle(1'b0, 1'b1, 32'h400, 1'b0, 32'd0, 32'd0, 4'd0);
    idle(14);

    // reset mid-wait; the late memory_ready must be ignored
    mem_lat = 4;
    cycle(1'b0, 1'b1, 32'h500, 1'b0, 32'd0, 32'd0, 4'd0);
    idle(2);
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0);
    idle(8);
    check_eq("rst_mid_no_iready", imem_ready, 32'd0);

    // randomized traffic
    mem_fix = 1'b0; mem_lat = -1; spur_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] ws;
      ws = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      cycle(($urandom_range(0, 499) == 0), ($urandom_range(0, 2) == 0), $urandom,
            ($urandom_range(0, 2) == 0), $urandom, $urandom, ws);
    end
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
